sync_fifo_ctrl: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 25 ++
 rtl/sync_fifo_ram.sv | 49 ++++
 rtl/sync_fifo_ctrl.sv | 141 ++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers and threshold legality checks for sync_fifo_ctrl
package sync_fifo_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int ptr_width(input int addr_width);
        return addr_width;
    endfunction

    // One extra bit so a completely full FIFO (DEPTH entries) is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit afull_th_legal(input int th, input int addr_width);
        return (th >= 1) && (th <= fifo_depth(addr_width));
    endfunction

    function automatic bit aempty_th_legal(input int th, input int addr_width);
        return (th >= 0) && (th < fifo_depth(addr_width));
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port storage array, DEPTH x DATA_WIDTH
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  rd_clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_comb_read
        logic unused_rd_ctrl;
        assign unused_rd_ctrl = &{1'b0, clr, rd_clr, rd_en};
        assign rd_data = mem[rd_addr];
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_q;
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                rd_q <= '0;
            end else if (rd_clr) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= mem[rd_addr];
            end
        end
        assign rd_data = rd_q;
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO controller: pointers, count, flags, error flags
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 4,
    parameter int FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  flush,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   use_num,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    if (!afull_th_legal(AFULL_TH, ADDR_WIDTH)) begin : g_bad_afull_th
        $error("sync_fifo_ctrl: AFULL_TH must lie in 1..DEPTH");
    end
    if (!aempty_th_legal(AEMPTY_TH, ADDR_WIDTH)) begin : g_bad_aempty_th
        $error("sync_fifo_ctrl: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [CW-1:0]         use_next;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Acceptance looks only at pre-edge flags: no bypass through an empty
    // FIFO and no write into a full one even when a read frees a slot.
    assign wr_acc = wr_req & ~full  & ~flush;
    assign rd_acc = rd_req & ~empty & ~flush;

    always_comb begin
        use_next = use_num;
        if (flush) begin
            use_next = '0;
        end else if (wr_acc && !rd_acc) begin
            use_next = use_num + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            use_next = use_num - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            use_num      <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            // Flags follow the next-state count so they agree with use_num.
            use_num      <= use_next;
            empty        <= (use_next == '0);
            full         <= (use_next == DEPTH_C);
            almost_empty <= (use_next <= AEMPTY_C);
            almost_full  <= (use_next >= AFULL_C);
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (wr_req && full) begin
                    overflow <= 1'b1;
                end
                if (rd_req && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk     (clk),
        .clr     (clr),
        .rd_clr  (flush),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        // The head word is only meaningful while non-empty; show zero otherwise.
        assign rd_data  = empty ? '0 : ram_rd_data;
        assign rd_valid = ~empty;
    end else begin : g_reg_read
        logic rd_valid_q;
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                rd_valid_q <= 1'b0;
            end else if (flush) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
            end
        end
        assign rd_data  = ram_rd_data;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - scoreboard bench for sync_fifo_ctrl in FWFT and registered-read modes
module tb_sync_fifo_ctrl;

    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          flush;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          rd_req;

    logic [DW-1:0] rd_data_f, rd_data_r;
    logic          rd_valid_f, rd_valid_r;
    logic [AW:0]   use_num_f, use_num_r;
    logic          empty_f, full_f, aempty_f, afull_f, ov_f, un_f;
    logic          empty_r, full_r, aempty_r, afull_r, ov_r, un_r;

    int n_chk  = 0;
    int n_fail = 0;

    int mq[$];
    int exp_f[$];
    int exp_r[$];
    bit m_ov, m_un, m_v0;
    int m_last0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(1)) u_dut_fwft (
        .clk(clk), .clr(clr), .flush(flush), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
        .rd_data(rd_data_f), .rd_valid(rd_valid_f), .use_num(use_num_f), .empty(empty_f), .full(full_f),
        .almost_empty(aempty_f), .almost_full(afull_f), .overflow(ov_f), .underflow(un_f)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(0)) u_dut_reg (
        .clk(clk), .clr(clr), .flush(flush), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
        .rd_data(rd_data_r), .rd_valid(rd_valid_r), .use_num(use_num_r), .empty(empty_r), .full(full_r),
        .almost_empty(aempty_r), .almost_full(afull_r), .overflow(ov_r), .underflow(un_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        chk("use_num", 32'(use_num_f), n);
        chk("empty", 32'(empty_f), 32'(n == 0));
        chk("full", 32'(full_f), 32'(n == DEPTH));
        chk("almost_empty", 32'(aempty_f), 32'(n <= AEMPTY));
        chk("almost_full", 32'(afull_f), 32'(n >= AFULL));
        chk("overflow", 32'(ov_f), 32'(m_ov));
        chk("underflow", 32'(un_f), 32'(m_un));
        chk("rd_valid_fwft", 32'(rd_valid_f), 32'(n > 0));
        chk("rd_data_fwft", 32'(rd_data_f), (n > 0) ? mq[0] : 0);
        chk("use_num_reg", 32'(use_num_r), n);
        chk("flags_reg", {26'd0, empty_r, full_r, aempty_r, afull_r, ov_r, un_r},
            {26'd0, n == 0, n == DEPTH, n <= AEMPTY, n >= AFULL, m_ov, m_un});
        chk("rd_valid_reg", 32'(rd_valid_r), 32'(m_v0));
        chk("rd_data_reg", 32'(rd_data_r), m_last0);
    endtask

    // Model advances to the post-edge state at the moment the inputs are driven.
    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit fl);
        int n;
        int d;
        @(negedge clk);
        #1;
        check_state();
        n = mq.size();
        if (fl) begin
            mq.delete();
            m_ov = 0;
            m_un = 0;
            m_v0 = 0;
            m_last0 = 0;
        end else begin
            if (wr && n == DEPTH) m_ov = 1;
            if (rd && n == 0) m_un = 1;
            m_v0 = 0;
            if (rd && n > 0) begin
                d = mq.pop_front();
                exp_f.push_back(d);
                exp_r.push_back(d);
                m_last0 = d;
                m_v0 = 1;
            end
            if (wr && n < DEPTH) mq.push_back(int'(wd));
        end
        wr_req  = wr;
        wr_data = wd;
        rd_req  = rd;
        flush   = fl;
    endtask

    task automatic do_clr();
        @(negedge clk);
        #1;
        check_state();
        wr_req = 0;
        rd_req = 0;
        flush  = 0;
        clr    = 1;
        #1;
        chk("clr_async_use_num", 32'(use_num_f), 0);
        chk("clr_async_rd_valid_reg", 32'(rd_valid_r), 0);
        mq.delete();
        exp_r.delete();
        m_ov = 0;
        m_un = 0;
        m_v0 = 0;
        m_last0 = 0;
        @(negedge clk);
        #1;
        clr = 0;
    endtask

    // Monitor: pops the scoreboard whenever either DUT presents a popped word.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rd_req && rd_valid_f && !flush && !clr) begin
                if (exp_f.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL fwft_pop: unexpected pop of %0h, none expected", rd_data_f);
                end else begin
                    chk("fwft_pop", 32'(rd_data_f), exp_f.pop_front());
                end
            end
            if (rd_valid_r) begin
                if (exp_r.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL reg_pop: unexpected rd_valid with %0h, none expected", rd_data_r);
                end else begin
                    chk("reg_pop", 32'(rd_data_r), exp_r.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        clr = 0; flush = 0; wr_req = 0; rd_req = 0; wr_data = '0;
        m_ov = 0; m_un = 0; m_v0 = 0; m_last0 = 0;
        #1 clr = 1;
        @(negedge clk);
        #1;
        check_state();
        clr = 0;

        // Reset mid-stream, then a simple write/read.
        for (int i = 0; i < 5; i++) step(1, 16'(i + 'h100), 0, 0);
        do_clr();
        step(1, 16'hA5A5, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Fill, partial drain, wrap, full drain.
        for (int i = 0; i < 16; i++) step(1, 16'(i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 16'(16 + i), 0, 0);
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Simultaneous traffic at 8 entries, then at full.
        for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 16'($urandom), 1, 0);
        for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0);
        step(1, 16'h7777, 1, 0);
        for (int i = 0; i < 15; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);

        // Sticky error flags and their clearing by flush.
        for (int i = 0; i < 16; i++) step(1, 16'(16'h3000 + i), 0, 0);
        step(1, 16'hDEAD, 0, 0);
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);

        // Registered-read latency and hold.
        step(1, 16'h1234, 0, 0);
        step(1, 16'h5678, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0);

        // Flush beats simultaneous write and read.
        for (int i = 0; i < 3; i++) step(1, 16'(16'h2000 + i), 0, 0);
        step(1, 16'h1111, 1, 1);
        step(0, '0, 0, 0);
        step(1, 16'hBEEF, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Random traffic: write-heavy then balanced, with rare flushes.
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 99) < 80, 16'($urandom), $urandom_range(0, 99) < 35, $urandom_range(0, 63) == 0);
        for (int i = 0; i < 250; i++)
            step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 55, $urandom_range(0, 63) == 0);
        for (int i = 0; i < 20; i++) step(0, '0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0);

        chk("exp_fwft_drained", exp_f.size(), 0);
        chk("exp_reg_drained", exp_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
